// File: rtl/fmul_pkg.sv
// rtl/fmul_pkg.sv - shared widths and defaults for the multiplier scheduler
package fmul_pkg;

    localparam int FP_W        = 32;
    localparam int DEF_N       = 4;
    localparam int DEF_MUL_LAT = 2;

    // requester id width; a single requester bit is still kept for N=2
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fmul_sched_if.sv
// rtl/fmul_sched_if.sv - requester, multiplier and response signals of the scheduler
interface fmul_sched_if
    import fmul_pkg::*;
#(
    parameter int N = DEF_N
);

    logic [N-1:0]      req_valid;
    logic [N*FP_W-1:0] req_a;
    logic [N*FP_W-1:0] req_b;
    logic [N-1:0]      req_ready;
    logic [FP_W-1:0]   mul_a;
    logic [FP_W-1:0]   mul_b;
    logic [FP_W-1:0]   mul_result;
    logic [N-1:0]      resp_valid;
    logic [FP_W-1:0]   resp_data;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, mul_result,
        input  req_ready, mul_a, mul_b, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_result,
        output req_ready, mul_a, mul_b, resp_valid, resp_data, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a priority pointer
module rr_arbiter
    import fmul_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    int   idx;
    logic found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            for (int j = 0; j < N; j++) begin
                if (!found && (j == idx) && req[j]) begin
                    grant[j] = 1'b1;
                    grant_id = ID_W'(j);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fmul_sched.sv
// rtl/fmul_sched.sv - shares one pipelined float multiplier among N requesters
// with round-robin issue and id-tagged result routing.
module fmul_sched
    import fmul_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic        clk,
    input  logic        rst,
    fmul_sched_if.slave bus
);

    localparam int ID_W = id_width(N);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gid;
    logic [N-1:0]    grant;
    logic            fire;
    logic [N-1:0]    resp_oh;

    logic            tag_v  [0:MUL_LAT];
    logic [ID_W-1:0] tag_id [0:MUL_LAT];
    logic            any_tag;

    rr_arbiter #(.N(N), .ID_W(ID_W)) u_arb (
        .req      (bus.req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (gid)
    );

    assign bus.req_ready = grant;
    assign fire          = |(bus.req_valid & grant);

    // last tag stage lines up with mul_result for that operation
    always_comb begin
        resp_oh = '0;
        for (int i = 0; i < N; i++) begin
            resp_oh[i] = (tag_id[MUL_LAT] == ID_W'(i));
        end
    end

    always_comb begin
        any_tag = 1'b0;
        for (int i = 0; i <= MUL_LAT; i++) begin
            any_tag = any_tag | tag_v[i];
        end
    end

    assign bus.busy = any_tag | (|bus.resp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr            <= '0;
            bus.mul_a      <= '0;
            bus.mul_b      <= '0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            if (fire) begin
                bus.mul_a <= bus.req_a[int'(gid)*FP_W +: FP_W];
                bus.mul_b <= bus.req_b[int'(gid)*FP_W +: FP_W];
                ptr       <= (gid == ID_W'(N-1)) ? '0 : gid + 1'b1;
            end
            tag_v[0]  <= fire;
            tag_id[0] <= gid;
            for (int i = 1; i <= MUL_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            bus.resp_valid <= tag_v[MUL_LAT] ? resp_oh : '0;
            if (tag_v[MUL_LAT]) begin
                bus.resp_data <= bus.mul_result;
            end
        end
    end

endmodule

// File: doc/fmul_sched.md
Name: fmul_sched

Overview:
- Shares one FloatingMultiply instance (IEEE-754 single precision, registered output, fixed latency) between N requesters.
- Round-robin arbitration with a valid/ready handshake on the request side.
- Drives the multiplier operands and tags each issued operation with its requester id.
- Routes each result back to its originating requester with a one-hot response strobe; sustains one multiply per clock.

Parameters:
- N, 4, number of requesters (2..8).
- MUL_LAT, 2, clocks from mul_a/mul_b change to the matching mul_result being valid.
- FP_W, 32, float word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N  per-requester request valid.
- req_a  in  N*FP_W  operand A; requester i occupies bits [i*FP_W +: FP_W].
- req_b  in  N*FP_W  operand B, same packing as req_a.
- req_ready  out  N  one-hot grant; transfer occurs when req_valid[i] && req_ready[i].
- mul_a  out  FP_W  operand A to the multiplier.
- mul_b  out  FP_W  operand B to the multiplier.
- mul_result  in  FP_W  multiplier output.
- resp_valid  out  N  one-hot, one-cycle response strobe.
- resp_data  out  FP_W  product; meaningful only while resp_valid != 0.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Reset (async assert, sync release):
  - mul_a, mul_b, resp_data = 0; resp_valid = 0; busy = 0.
  - All tag stages invalid.
  - Priority pointer = 0, so requester 0 has highest priority first.
- Arbitration is combinational within the cycle:
  - Scan req_valid starting at the pointer, wrapping modulo N; the first set bit gets req_ready.
  - At most one req_ready bit is high. req_ready = 0 when no req_valid is set.
  - req_ready does not depend on downstream state; there is no backpressure.
- On a handshake with requester g at edge T:
  - mul_a/mul_b <= req_a[g]/req_b[g].
  - Tag stage 0 <= {valid=1, id=g}.
  - Pointer <= (g+1) mod N.
- With no handshake: mul_a/mul_b hold their value (no toggling); tag stage 0 <= invalid; pointer holds.
- Tag pipeline:
  - MUL_LAT further stages, each shifted every clock.
  - At edge T+1+MUL_LAT the final stage latches mul_result into resp_data and sets resp_valid[id] for exactly one cycle.
  - End-to-end latency: handshake edge T to response visible after edge T+1+MUL_LAT, i.e. 1+MUL_LAT cycles (3 at default).
- Throughput: back-to-back grants on consecutive cycles. Responses return in issue order, one per cycle.
- Fairness: a continuously asserting requester waits at most N-1 grants.
- busy = OR of the valid bits of all tag stages, plus the output stage.
- Requesters must accept responses unconditionally. A requester may have any number of operations outstanding.
- Multiply results are passed through unmodified; the block performs no special-case (NaN/Inf/denormal) handling.
- Reset mid-operation: all in-flight operations are discarded and no resp_valid is ever produced for them. Pointer returns to 0.
- req_valid dropping without a handshake is legal; no state changes.

Decomposition:
- Package fmul_pkg: FP_W, default MUL_LAT, and localparam ID_W = clog2(N), minimum 1.
- One sub-module, rr_arbiter (N): inputs req, pointer; outputs one-hot grant and encoded grant id.
- Operand mux, tag pipeline and response register stay in fmul_sched.
- FloatingMultiply is instantiated outside, at the level above.

Test Plan:
- Single request: req 0 with a=0x447A0000 (1000), b=0xC1200000 (-10) -> req_ready[0] same cycle; resp_valid=0b0001 with resp_data=0xC61C4000 exactly 3 cycles later; busy high in between.
- All four requesters valid for 8 cycles after reset, each with distinct operands (e.g. 32×32=0x44800000, 32×5=0x43200000) -> grants in order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle, each with the correct product.
- Requesters 1 and 3 only, pointer at 2 -> grant 3 first, then 1, then 3.
- Back-to-back stream from requester 2 for 5 cycles -> 5 consecutive resp_valid=0b0100 pulses; mul_a holds its last value afterwards.
- Assert rst one cycle after issuing 2 operations -> no resp_valid for either; busy=0; next request issues from pointer 0.
- Idle bus (req_valid=0) -> req_ready=0, resp_valid=0, mul_a/mul_b unchanged.
